intr_pending_ctrl: RTL and testbench

INTR_PENDING_CTRL -- requirements
Module: intr_pending_ctrl

---
 rtl/intr_pending_ctrl_pkg.sv | 19 +
 rtl/intr_pending_ctrl_line.sv | 135 +++++++++++++
 rtl/intr_pending_ctrl.sv | 49 ++++
 tb/tb_intr_pending_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/intr_pending_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// intr_pending_ctrl_pkg
// Shared definitions for the interrupt pending controller: line count,
// per-line FSM state encoding and trigger-mode constants.
// ---------------------------------------------------------------------------
package intr_pending_ctrl_pkg;

   localparam int INTR_N = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      ACKD = 2'd2
   } line_state_t;

   localparam logic MODE_LEVEL = 1'b0;
   localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/intr_pending_ctrl_line.sv
// ---------------------------------------------------------------------------
// intr_line
// One interrupt line: optional input synchronizer, edge detector, the
// IDLE/PEND/ACKD pending FSM and the sticky overflow (lost edge) flag.
//
// Configuration macro: INTR_SYNC_EN -- when defined, ext_irq passes through a
// two-flop synchronizer (ext_irq rise to intr_in: 3 cycles); otherwise
// ext_irq must be clk-synchronous and is used directly (1 cycle).
//
// Ports:
//   clk       clock, all state on rising edge
//   reset     asynchronous active-high reset
//   ext_irq   raw interrupt source
//   irq_mode  0 = level-high, 1 = rising edge
//   irq_mask  1 = forward pending request on intr_in
//   intr_ack  acknowledge from the downstream controller
//   ovf_clr   clears the overflow flag (a simultaneous set wins)
//   intr_in   pending & irq_mask
//   pending   line is in PEND
//   overflow  sticky flag: an edge arrived while already pending
// ---------------------------------------------------------------------------
module intr_line
   import intr_pending_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic ext_irq,
   input  logic irq_mode,
   input  logic irq_mask,
   input  logic intr_ack,
   input  logic ovf_clr,
   output logic intr_in,
   output logic pending,
   output logic overflow
);

   logic        s;          // sampled source
   logic        s_valid;    // s reflects a real observation of ext_irq
   logic        s_d_q;
   logic        armed_q;    // source has been seen low since reset
   logic        rem_q;      // edge remembered while in ACKD
   logic        ovf_q;
   logic        edge_det;
   logic        edge_trig;
   logic        trig;
   line_state_t state_q;
   line_state_t state_d;

`ifdef INTR_SYNC_EN
   logic       sync1_q;
   logic       sync2_q;
   logic [1:0] valid_q;

   // valid_q tracks how long the synchronizer has been filling since reset,
   // so that its zero reset contents are not mistaken for a low source.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         valid_q <= 2'b00;
      end else begin
         sync1_q <= ext_irq;
         sync2_q <= sync1_q;
         valid_q <= {valid_q[0], 1'b1};
      end
   end

   assign s       = sync2_q;
   assign s_valid = valid_q[1];
`else
   assign s       = ext_irq;
   assign s_valid = 1'b1;
`endif

   // An edge only counts once the source has been observed low after reset,
   // so a source already high at reset release does not fire in edge mode.
   assign edge_det  = s & ~s_d_q & armed_q;
   assign edge_trig = (irq_mode == MODE_EDGE) & edge_det;
   assign trig      = (irq_mode == MODE_EDGE) ? edge_det : s;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         s_d_q   <= 1'b0;
         armed_q <= 1'b0;
         rem_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_d_q   <= s;
         armed_q <= armed_q | (s_valid & ~s);

         if (state_q == ACKD && state_d == ACKD)
            rem_q <= rem_q | edge_trig;
         else
            rem_q <= 1'b0;

         // Set has priority over clear.
         if (state_q == PEND && edge_trig)
            ovf_q <= 1'b1;
         else if (ovf_clr)
            ovf_q <= 1'b0;
      end
   end

   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (trig) state_d = PEND;
         PEND: if (intr_ack) state_d = ACKD;
         ACKD: begin
            if (!intr_ack) begin
               if (rem_q || edge_trig)
                  state_d = PEND;
               else if (irq_mode == MODE_LEVEL && s)
                  state_d = ACKD;   // level still asserted: wait for it to drop
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;   // unused encoding recovers
      endcase
   end

   always_comb begin
      pending  = (state_q == PEND);
      intr_in  = pending & irq_mask;
      overflow = ovf_q;
   end

endmodule

// File: rtl/intr_pending_ctrl.sv
// ---------------------------------------------------------------------------
// intr_pending_ctrl
// Per-line interrupt pending controller: INTR_N independent intr_line
// instances, no priority between lines.
//
// Configuration macro: INTR_SYNC_EN (see intr_line).
//
// Ports (all INTR_N bits wide except clk/reset):
//   clk, reset  clock and asynchronous active-high reset
//   ext_irq     raw interrupt sources
//   irq_mode    per-line trigger mode, 0 = level, 1 = edge
//   irq_mask    per-line forward enable
//   intr_ack    per-line acknowledge
//   ovf_clr     per-line overflow clear
//   intr_in     masked pending requests
//   pending     unmasked pending status
//   overflow    sticky lost-edge flags
// ---------------------------------------------------------------------------
module intr_pending_ctrl
   import intr_pending_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [INTR_N-1:0] ext_irq,
   input  logic [INTR_N-1:0] irq_mode,
   input  logic [INTR_N-1:0] irq_mask,
   input  logic [INTR_N-1:0] intr_ack,
   input  logic [INTR_N-1:0] ovf_clr,
   output logic [INTR_N-1:0] intr_in,
   output logic [INTR_N-1:0] pending,
   output logic [INTR_N-1:0] overflow
);

   for (genvar i = 0; i < INTR_N; i++) begin : g_line
      intr_line u_line (
         .clk      (clk),
         .reset    (reset),
         .ext_irq  (ext_irq[i]),
         .irq_mode (irq_mode[i]),
         .irq_mask (irq_mask[i]),
         .intr_ack (intr_ack[i]),
         .ovf_clr  (ovf_clr[i]),
         .intr_in  (intr_in[i]),
         .pending  (pending[i]),
         .overflow (overflow[i])
      );
   end

endmodule

// File: tb/tb_intr_pending_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_pending_ctrl
// Directed self-checking bench for intr_pending_ctrl. Inputs change and
// outputs are sampled on the falling edge; LAT is the ext_irq-to-PEND
// latency of the selected build.
// ---------------------------------------------------------------------------
module tb_intr_pending_ctrl;

`ifdef INTR_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] ext_irq, irq_mode, irq_mask, intr_ack, ovf_clr;
   logic [1:0] intr_in, pending, overflow;

   int total = 0;
   int bad   = 0;

   intr_pending_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .ext_irq  (ext_irq),
      .irq_mode (irq_mode),
      .irq_mask (irq_mask),
      .intr_ack (intr_ack),
      .ovf_clr  (ovf_clr),
      .intr_in  (intr_in),
      .pending  (pending),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cycn(input int n);
      repeat (n) cyc();
   endtask

   // One-cycle high pulse on the selected lines, then LAT low cycles so the
   // edge has been processed and the sampled source is low again.
   task automatic pulse(input logic [1:0] lines);
      ext_irq = ext_irq | lines;
      cyc();
      ext_irq = ext_irq & ~lines;
      cycn(LAT);
   endtask

   initial begin
      reset    = 1'b1;
      ext_irq  = 2'b00;
      irq_mode = 2'b00;
      irq_mask = 2'b11;
      intr_ack = 2'b00;
      ovf_clr  = 2'b00;
      @(negedge clk);
      cycn(2);
      check("rst_intr_in",  intr_in,  2'b00);
      check("rst_pending",  pending,  2'b00);
      check("rst_overflow", overflow, 2'b00);
      reset = 1'b0;
      cycn(4);

      // Level line 0
      ext_irq = 2'b01;
      cycn(LAT - 1);
      check("lvl_not_yet", intr_in, 2'b00);
      cyc();
      check("lvl_intr_in", intr_in, 2'b01);
      check("lvl_pending", pending, 2'b01);
      cycn(2);
      intr_ack = 2'b01;
      cyc();
      check("lvl_acked", intr_in, 2'b00);
      intr_ack = 2'b00;
      cycn(2);
      check("lvl_no_retrig", pending, 2'b00);
      ext_irq = 2'b00;
      cycn(LAT + 1);
      check("lvl_idle", pending, 2'b00);
      ext_irq = 2'b01;
      cycn(LAT);
      check("lvl_rearm", pending, 2'b01);
      ext_irq  = 2'b00;
      intr_ack = 2'b01;
      cyc();
      intr_ack = 2'b00;
      cycn(LAT + 1);
      check("lvl_done", pending, 2'b00);

      // Edge line 1: pending, overflow, clear
      irq_mode = 2'b10;
      cyc();
      pulse(2'b10);
      check("edge_pending",  pending,  2'b10);
      check("edge_intr_in",  intr_in,  2'b10);
      check("edge_no_ovf",   overflow, 2'b00);
      pulse(2'b10);
      check("edge_ovf",      overflow, 2'b10);
      check("edge_single",   pending,  2'b10);
      ovf_clr = 2'b10;
      cyc();
      ovf_clr = 2'b00;
      check("edge_ovf_clr",  overflow, 2'b00);
      check("edge_still",    pending,  2'b10);
      intr_ack = 2'b10;
      cyc();
      intr_ack = 2'b00;
      cyc();
      check("edge_idle",     pending,  2'b00);

      // Edge line 0: edge during ACKD is remembered
      irq_mode = 2'b11;
      cyc();
      pulse(2'b01);
      check("ackd_pend",    pending, 2'b01);
      intr_ack = 2'b01;
      cyc();
      check("ackd_enter",   pending, 2'b00);
      pulse(2'b01);
      check("ackd_hold",    pending, 2'b00);
      intr_ack = 2'b00;
      cyc();
      check("ackd_reenter", pending, 2'b01);
      check("ackd_no_ovf",  overflow, 2'b00);
      intr_ack = 2'b01;
      cyc();
      intr_ack = 2'b00;
      cyc();
      check("ackd_done",    pending, 2'b00);

      // Masking
      irq_mask = 2'b00;
      pulse(2'b11);
      check("mask_pending", pending, 2'b11);
      check("mask_intr_in", intr_in, 2'b00);
      irq_mask = 2'b01;
      #1;
      check("unmask_same_cycle", intr_in, 2'b01);
      @(negedge clk);
      pulse(2'b10);
      pulse(2'b01);
      check("both_ovf", overflow, 2'b11);

      // Reset mid-operation, line 0 level held high, line 1 edge held high
      irq_mode = 2'b10;
      ext_irq  = 2'b11;
      cyc();
      reset = 1'b1;
      #1;
      check("mid_rst_pending",  pending,  2'b00);
      check("mid_rst_intr_in",  intr_in,  2'b00);
      check("mid_rst_overflow", overflow, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      cycn(LAT);
      check("rst_lvl_retrig", pending, 2'b01);
      check("rst_lvl_intr",   intr_in, 2'b01);
      cycn(3);
      check("rst_edge_quiet", pending, 2'b01);
      ext_irq = 2'b01;
      cycn(LAT + 1);
      pulse(2'b10);
      check("rst_edge_after_fall", pending, 2'b11);

      // Overflow set and clear in the same cycle: set wins
      ext_irq = ext_irq | 2'b10;
      for (int k = 1; k <= LAT; k++) begin
         if (k == LAT) ovf_clr = 2'b10;
         cyc();
         if (k == 1) ext_irq = ext_irq & ~2'b10;
      end
      ovf_clr = 2'b00;
      check("ovf_set_wins", overflow, 2'b10);
      ovf_clr = 2'b10;
      cyc();
      ovf_clr = 2'b00;
      check("ovf_clr_after", overflow, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
